dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer for the byte-addressed data memory (1 KiB, byte-enabled writes, combinational 32-bit read).
- Port 0 is the core load/store path; port 1 is the debug/DMA path.
- Accepts one request at a time via a valid/ready handshake and drives the memory for exactly one cycle.
- Returns a registered response pulse, with read data for loads.

Parameters:
- ADDR_BITS, 10, byte-address width; must match the memory's ADDR_BITS.
- FAIR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- p0_valid  input  1  port 0 request valid
- p0_ready  output  1  port 0 request accepted this cycle
- p0_we  input  1  port 0: 1 = store, 0 = load
- p0_addr  input  ADDR_BITS  port 0 byte address
- p0_wdata  input  32  port 0 store data, lane-aligned
- p0_be  input  4  port 0 byte enables; stores only
- p0_rsp_valid  output  1  port 0 access complete, one-cycle pulse
- p0_rdata  output  32  port 0 load data; valid with p0_rsp_valid
- p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_be, p1_rsp_valid, p1_rdata: same widths and meaning for port 1
- mem_read  output  1  to memory
- mem_write  output  1  to memory
- mem_addr  output  ADDR_BITS  to memory addr
- mem_wdata  output  32  to memory write_data
- mem_be  output  4  to memory byte_enable
- mem_rdata  input  32  from memory mem_data_out, combinational

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset value: IDLE.
- Reset values:
  - all rsp_valid = 0; all rdata = 0
  - last_grant = 1, so port 0 wins the first tie
  - captured request registers = 0
- Memory outputs are combinational from state and captured registers:
  - mem_read = (ACCESS & !we_q); mem_write = (ACCESS & we_q)
  - mem_addr, mem_wdata, mem_be = captured values
  - All memory outputs are 0 outside ACCESS.
- Grant logic, combinational, IDLE only:
  - Only one valid → that port is granted.
  - Both valid, FAIR=1 → the port not equal to last_grant is granted.
  - Both valid, FAIR=0 → port 0 is granted.
  - px_ready = IDLE & grant_x. Never both high. ready is 0 in ACCESS and RESP.
- Handshake transfer on an edge where valid & ready:
  - capture we, addr, wdata, be and port id; update last_grant; go to ACCESS.
  - Requester must drop or replace valid after the transfer edge.
  - valid may rise or fall freely while ready = 0. There is no obligation to hold valid.
- ACCESS lasts exactly one cycle:
  - Store: the memory commits on the edge ending ACCESS.
  - Load: rdata of the granted port ← mem_rdata on that edge.
  - Then go to RESP.
- RESP lasts exactly one cycle:
  - prsp_valid of the captured port = 1; the other port's rsp_valid = 0.
  - Go to IDLE.
- rdata holds its last value until the next load on that port. Stores do not alter rdata.
- Latency and throughput:
  - Handshake edge at cycle N → ACCESS in N+1 → rsp_valid high in N+2.
  - Next grant is possible in N+3, so at most 1 access per 3 cycles.
- Write data and be pass through unchanged. The memory handles byte lanes and address+1..+3 wrap modulo 2^ADDR_BITS; the arbiter does no alignment checks.
- be is ignored for loads; all 4 bytes are always read.
- The other port's request arriving during ACCESS/RESP waits. It is arbitrated on return to IDLE.
- Reset asserted mid-ACCESS/RESP:
  - immediate return to IDLE; memory outputs go to 0; no rsp_valid issued.
  - A store whose ACCESS edge coincides with reset assertion is not guaranteed to commit.

Test Plan:
- Store then load, port 0: store addr 0x010, wdata 0xDEADBEEF, be 0xF; then load 0x010 → p0_rsp_valid exactly 2 cycles after each handshake, p0_rdata = 0xDEADBEEF.
- Byte-enable pass-through: store 0x11223344 be 0xF at 0x020, then store 0x000000AA be 0x1 → p1 load of 0x020 returns 0x112233AA.
- Contention with FAIR=1:
  - p0 and p1 both valid continuously from reset with distinct loads.
  - Grants go p0, p1, p0, p1; ready pulses are 3 cycles apart.
  - rsp_valid goes only to the owning port.
- FAIR=0 starvation check: both valid for 4 handshakes → all 4 grants to port 0, p1_ready never high.
- Wrap-around: store 0xCAFEF00D at 0x3FE be 0xF, load 0x3FE → 0xCAFEF00D; load 0x000 upper half reflects wrapped bytes 0xCAFE in bits 15:0.
- Reset mid-ACCESS: assert rst during ACCESS of a load → all outputs return to reset values asynchronously, no rsp_valid. After release, next request completes normally with last_grant = 1 behaviour (port 0 wins tie).

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-cycle access sequencer for the byte-addressed data memory.
// Port 0 is the core load/store path, port 1 the debug/DMA path; one request in flight at a time.
module dmem_arbiter #(
    parameter int ADDR_BITS = 10,
    parameter int FAIR      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 p0_valid,
    output logic                 p0_ready,
    input  logic                 p0_we,
    input  logic [ADDR_BITS-1:0] p0_addr,
    input  logic [31:0]          p0_wdata,
    input  logic [3:0]           p0_be,
    output logic                 p0_rsp_valid,
    output logic [31:0]          p0_rdata,
    input  logic                 p1_valid,
    output logic                 p1_ready,
    input  logic                 p1_we,
    input  logic [ADDR_BITS-1:0] p1_addr,
    input  logic [31:0]          p1_wdata,
    input  logic [3:0]           p1_be,
    output logic                 p1_rsp_valid,
    output logic [31:0]          p1_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_be,
    input  logic [31:0]          mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                 state_q, state_d;
    logic                   we_q, we_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic                   port_q, port_d;
    logic                   last_grant_q, last_grant_d;
    logic [1:0]             rsp_valid_q, rsp_valid_d;
    logic [31:0]            rdata0_q, rdata0_d;
    logic [31:0]            rdata1_q, rdata1_d;
    logic                   grant0, grant1;

    // On a tie, round-robin hands the grant to whichever port did not win last time.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            if (p0_valid && p1_valid) begin
                if ((FAIR != 0) && !last_grant_q) grant1 = 1'b1;
                else                              grant0 = 1'b1;
            end else begin
                grant0 = p0_valid;
                grant1 = p1_valid;
            end
        end
    end

    assign p0_ready = grant0;
    assign p1_ready = grant1;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        rsp_valid_d  = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    we_d         = grant1 ? p1_we    : p0_we;
                    addr_d       = grant1 ? p1_addr  : p0_addr;
                    wdata_d      = grant1 ? p1_wdata : p0_wdata;
                    be_d         = grant1 ? p1_be    : p0_be;
                    port_d       = grant1;
                    last_grant_d = grant1;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (port_q) rdata1_d = mem_rdata;
                    else        rdata0_d = mem_rdata;
                end
                rsp_valid_d = port_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            port_q       <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid_q  <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign p0_rsp_valid = rsp_valid_q[0];
    assign p1_rsp_valid = rsp_valid_q[1];
    assign p0_rdata     = rdata0_q;
    assign p1_rdata     = rdata1_q;

    // Memory is only driven during the single ACCESS cycle; quiet otherwise.
    assign mem_read  = (state_q == ACCESS) && !we_q;
    assign mem_write = (state_q == ACCESS) &&  we_q;
    assign mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign mem_be    = (state_q == ACCESS) ? be_q    : '0;

endmodule
